// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Instruction fetch: pc register, imem request and in-order fetch queue toward decode.
// Optional EBREAK halt selected by macro FETCH_EBREAK_HALT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       ent_pc_q    [DEPTH];
    logic [31:0]       ent_instr_q [DEPTH];
    logic              push;
    logic              pop;

    assign imem_addr   = pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? ent_instr_q[head_q] : '0;
    assign instr_pc    = instr_valid ? ent_pc_q[head_q]    : '0;

`ifdef FETCH_EBREAK_HALT_EN
    assign halted = (state_q == ST_HALT);
`else
    assign halted = 1'b0;
`endif

    assign pop  = instr_valid & instr_ready;
    assign push = (state_q == ST_RUN) & ~redirect_valid
                & ((count_q < CNT_W'(DEPTH)) | pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (redirect_valid) begin
            // Redirect wins over any pop/push in the same cycle.
            state_d = ST_RUN;
            pc_d    = redirect_pc & 32'hFFFF_FFFC;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_d   = pc_q + 32'd4;
                tail_d = tail_q + PTR_W'(1);
`ifdef FETCH_EBREAK_HALT_EN
                if (imem_rdata == 32'h0010_0073) begin
                    state_d = ST_HALT;
                end
`endif
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_pc_q[tail_q]    <= pc_q;
            ent_instr_q[tail_q] <= imem_rdata;
        end
    end

endmodule
